// File: rtl/cpu_sequencer_if.sv
// Purpose: fetch and load/store handshake between cpu_sequencer and memory_arbiter.
// Latency: none, plain wires.
// Backpressure: none here; the arbiter stalls the sequencer by withholding fetch_valid / mem_done.
interface cpu_sequencer_if;
    logic fetch_req;      // arbiter pc_valid, one-cycle pulse
    logic fetch_valid;    // arbiter instruction_valid
    logic mem_read_req;   // arbiter read_enable, level
    logic mem_write_req;  // arbiter write_enable, level
    logic mem_done;       // arbiter read_write_valid

    modport master (
        output fetch_req,
        output mem_read_req,
        output mem_write_req,
        input  fetch_valid,
        input  mem_done
    );

    modport slave (
        input  fetch_req,
        input  mem_read_req,
        input  mem_write_req,
        output fetch_valid,
        output mem_done
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Purpose: multi-cycle FETCH/EXEC/MEM/WB control FSM for the rv32i core, with bus watchdog and perf counters.
// Latency: 4 cycles per ALU instruction with a 1-cycle fetch; loads/stores add one cycle per MEM wait cycle.
// Backpressure: waits in WAIT_F / MEM until fetch_valid / mem_done; a watchdog expiry there faults permanently.
module cpu_sequencer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    cpu_sequencer_if.master      bus,
    input  logic                 pc_stall,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 illegal_instr,
    output logic                 pc_update,
    output logic                 rf_write_en,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_cause,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Watchdog holds the number of bus-wait cycles already missed; the wait
    // cycle that sees this value is the last one allowed.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_TO  = 2'b10;
    localparam logic [1:0] CAUSE_MEM_TO    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_F,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    state_t                state_q, state_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [1:0]            cause_q, cause_d;
    logic [CNT_WIDTH-1:0]  cycle_q, instret_q;
    logic                  wd_expired;

    assign wd_expired = (wd_q == WD_LAST);

    // State, watchdog and latched fault cause.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic; a response arriving in the expiring wait cycle beats the watchdog.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: begin
                if (!pc_stall) state_d = S_FETCH;
            end
            S_FETCH: begin
                wd_d    = '0;
                state_d = S_WAIT_F;
            end
            S_WAIT_F: begin
                if (bus.fetch_valid) begin
                    state_d = S_EXEC;
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_FETCH_TO;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_EXEC: begin
                if (illegal_instr || (is_load && is_store)) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_ILLEGAL;
                end else if (is_load || is_store) begin
                    wd_d    = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.mem_done) begin
                    state_d = S_WB;
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_MEM_TO;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_WB: begin
                state_d = pc_stall ? S_IDLE : S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_WIDTH'(1);
            if (state_q == S_WB) instret_q <= instret_q + CNT_WIDTH'(1);
        end
    end

    // Strobes decode the state register only; memory requests follow the decoded op while in MEM.
    always_comb begin
        bus.fetch_req     = (state_q == S_FETCH);
        bus.mem_read_req  = (state_q == S_MEM) && is_load;
        bus.mem_write_req = (state_q == S_MEM) && is_store;
        pc_update         = (state_q == S_WB);
        rf_write_en       = (state_q == S_WB);
        halted            = (state_q == S_IDLE);
        fault             = (state_q == S_FAULT);
    end

    assign fault_cause   = cause_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Purpose: self-checking bench for cpu_sequencer; acts as arbiter and decoder and checks a per-instruction timeline.
// Latency: each instruction is laid out as FETCH, fetch wait, EXEC, memory wait, WB segments of known length.
// Backpressure: the bench chooses fetch and memory response delays, including never responding.
`timescale 1ns/1ps
module tb_cpu_sequencer;
    localparam int TO  = 4;
    localparam int CW  = 8;
    localparam int MOD = 1 << CW;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          pc_stall;
    logic          is_load;
    logic          is_store;
    logic          illegal_instr;
    logic          pc_update;
    logic          rf_write_en;
    logic          halted;
    logic          fault;
    logic [1:0]    fault_cause;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instret_count;

    cpu_sequencer_if bus();

    cpu_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .bus          (bus),
        .pc_stall     (pc_stall),
        .is_load      (is_load),
        .is_store     (is_store),
        .illegal_instr(illegal_instr),
        .pc_update    (pc_update),
        .rf_write_en  (rf_write_en),
        .halted       (halted),
        .fault        (fault),
        .fault_cause  (fault_cause),
        .cycle_count  (cycle_count),
        .instret_count(instret_count)
    );

    always #5 CLK = ~CLK;

    int n_chk   = 0;
    int n_fail  = 0;
    int ncyc    = 0;   // rising edges since reset release
    int retired = 0;   // instructions retired since reset release

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, ncyc, got, exp);
        end
    endtask

    function automatic logic rnd();
        return ($urandom_range(0, 1) == 1);
    endfunction

    // {halted, fault, fetch_req, mem_read_req, mem_write_req, pc_update, rf_write_en}
    function automatic logic [6:0] outs(input logic h, f, fr, mr, mw, pu, rw);
        return {h, f, fr, mr, mw, pu, rw};
    endfunction

    function automatic logic [6:0] obs();
        return {halted, fault, bus.fetch_req, bus.mem_read_req, bus.mem_write_req, pc_update, rf_write_en};
    endfunction

    // One clock cycle: drive this cycle's inputs after the edge, check outputs at the falling edge.
    task automatic step(input logic fv, md, stall, ld, st, ill, input logic [6:0] exp_o, input string ph);
        @(posedge CLK);
        ncyc++;
        #1;
        bus.fetch_valid = fv;
        bus.mem_done    = md;
        pc_stall        = stall;
        is_load         = ld;
        is_store        = st;
        illegal_instr   = ill;
        @(negedge CLK);
        chk(ph, obs(), exp_o);
        chk("cycle_count", cycle_count, ncyc % MOD);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " outputs"}, obs(), outs(1, 0, 0, 0, 0, 0, 0));
        chk({tag, " fault_cause"}, fault_cause, 2'b00);
        chk({tag, " cycle_count"}, cycle_count, 0);
        chk({tag, " instret_count"}, instret_count, 0);
    endtask

    // Asynchronous reset from the middle of a cycle; outputs must clear before any edge.
    task automatic reset_async();
        #2;
        RSTn            = 1'b0;
        pc_stall        = 1'b1;
        is_load         = 1'b0;
        is_store        = 1'b0;
        illegal_instr   = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.mem_done    = 1'b0;
        #1;
        check_reset_vals("async reset");
        @(posedge CLK);
        #3;
        RSTn    = 1'b1;
        ncyc    = 0;
        retired = 0;
        #1;
        check_reset_vals("after release");
    endtask

    // n cycles in IDLE; pc_stall is dropped in the last one so FETCH follows.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(rnd(), rnd(), (i < n - 1), rnd(), rnd(), rnd(), outs(1, 0, 0, 0, 0, 0, 0), "idle");
    endtask

    task automatic fault_phase(input logic [1:0] cause);
        for (int i = 0; i < 5; i++) begin
            step(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), outs(0, 1, 0, 0, 0, 0, 0), "fault");
            chk("fault_cause", fault_cause, cause);
            chk("instret in fault", instret_count, retired % MOD);
        end
        reset_async();
        idle($urandom_range(1, 3));
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 illegal, 4 load+store.
    // flat: cycle of the fetch wait carrying fetch_valid (0 = never).
    // mlat: cycle of the memory wait carrying mem_done (0 = never).
    task automatic run_instr(input int kind, input int flat, input int mlat, input logic stall);
        logic ld, st, ill;
        int   wait_len, mem_len;
        ld       = (kind == 1) || (kind == 4);
        st       = (kind == 2) || (kind == 4);
        ill      = (kind == 3);
        wait_len = (flat == 0) ? TO : flat;
        mem_len  = (mlat == 0) ? TO : mlat;

        step(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), outs(0, 0, 1, 0, 0, 0, 0), "fetch");
        for (int i = 1; i <= wait_len; i++)
            step((i == flat), rnd(), rnd(), rnd(), rnd(), rnd(), outs(0, 0, 0, 0, 0, 0, 0), "fetch wait");
        if (flat == 0) begin
            fault_phase(2'b10);
            return;
        end

        step(rnd(), rnd(), rnd(), ld, st, ill, outs(0, 0, 0, 0, 0, 0, 0), "exec");
        if (kind >= 3) begin
            fault_phase(2'b01);
            return;
        end

        if (ld || st) begin
            for (int j = 1; j <= mem_len; j++)
                step(rnd(), (j == mlat), rnd(), ld, st, rnd(), outs(0, 0, 0, ld, st, 0, 0), "mem wait");
            if (mlat == 0) begin
                fault_phase(2'b11);
                return;
            end
        end

        step(rnd(), rnd(), stall, ld, st, rnd(), outs(0, 0, 0, 0, 0, 1, 1), "writeback");
        chk("instret at writeback", instret_count, retired % MOD);
        retired++;
        if (stall) idle($urandom_range(1, 3));
    endtask

    initial begin
        RSTn            = 1'b0;
        pc_stall        = 1'b1;
        is_load         = 1'b0;
        is_store        = 1'b0;
        illegal_instr   = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.mem_done    = 1'b0;
        #12;
        check_reset_vals("power-on reset");
        @(posedge CLK);
        #3;
        RSTn = 1'b1;
        #1;
        check_reset_vals("after first release");

        idle(3);
        repeat (10) run_instr(0, 1, 0, 1'b0);
        run_instr(1, 1, 3, 1'b0);
        run_instr(2, 1, 3, 1'b0);
        run_instr(0, TO, 0, 1'b0);
        run_instr(1, 2, TO, 1'b0);
        run_instr(2, 1, 2, 1'b1);
        run_instr(0, 1, 0, 1'b1);
        run_instr(0, 0, 0, 1'b0);
        run_instr(2, 1, 0, 1'b0);
        run_instr(1, 3, 0, 1'b0);
        run_instr(3, 2, 0, 1'b0);
        run_instr(4, 1, 0, 1'b0);

        step(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), outs(0, 0, 1, 0, 0, 0, 0), "fetch");
        step(1'b0, rnd(), rnd(), rnd(), rnd(), rnd(), outs(0, 0, 0, 0, 0, 0, 0), "fetch wait");
        reset_async();
        idle(2);

        repeat (300)
            run_instr($urandom_range(0, 2), $urandom_range(1, TO), $urandom_range(1, TO),
                      ($urandom_range(0, 3) == 0));
        repeat (20)
            run_instr($urandom_range(0, 4), $urandom_range(0, TO), $urandom_range(0, TO),
                      ($urandom_range(0, 3) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
